// File: rtl/memory_latency_injector_mc_if.sv
// Request/response bus of the multi-channel latency injector.
// master: the requesting side (DMA engines / testbench) drives requests and
//         resp_ready, and sees req_ready and the response fields.
// slave:  the injector, which accepts requests and produces responses.
// Per-channel request fields are packed, with channel c at [c*W +: W].
interface memory_latency_injector_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int SIZE_WIDTH = 16,
  parameter int ID_WIDTH   = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH-1:0]            req_is_dram;
  logic [NUM_CH*SIZE_WIDTH-1:0] req_size_bytes;
  logic [NUM_CH*ID_WIDTH-1:0]   req_id;
  logic [NUM_CH-1:0]            req_ready;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [CH_W-1:0]              resp_ch;
  logic [ID_WIDTH-1:0]          resp_id;
  logic [SIZE_WIDTH-1:0]        resp_size_bytes;

  modport master (
    output req_valid, req_is_dram, req_size_bytes, req_id, resp_ready,
    input  req_ready, resp_valid, resp_ch, resp_id, resp_size_bytes
  );

  modport slave (
    input  req_valid, req_is_dram, req_size_bytes, req_id, resp_ready,
    output req_ready, resp_valid, resp_ch, resp_id, resp_size_bytes
  );
endinterface

// File: rtl/memory_latency_injector_mc.sv
// Multi-channel, multi-outstanding memory latency injector.
// NUM_CH request channels share a round-robin arbiter (one accept per cycle)
// and a pool of SLOTS outstanding slots. Each slot counts down an SRAM, DRAM
// miss (base + transfer time) or DRAM hit latency fixed at accept time, then
// retires out-of-order (lowest eligible slot) or strictly in acceptance order.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   bus (slave)            request channels and backpressured response
//   cfg_*                  runtime latencies, DRAM hit rate, ordering mode
//   total_reqs..busy_cycles  32-bit wrapping telemetry counters
//   max_occupancy          high-water mark of occupied slots
//   busy                   any slot occupied or response pending
module memory_latency_injector_mc #(
  parameter int          NUM_CH               = 2,
  parameter int          SIZE_WIDTH           = 16,
  parameter int          ID_WIDTH             = 4,
  parameter int          SLOTS                = 8,
  parameter int          LAT_WIDTH            = 16,
  parameter int          LATENCY_SRAM_CYCLES  = 2,
  parameter int          LATENCY_DRAM_CYCLES  = 30,
  parameter int          DRAM_BYTES_PER_CYCLE = 32,
  parameter logic [15:0] LFSR_SEED            = 16'h5A5A
) (
  input  logic                         clk,
  input  logic                         reset,
  memory_latency_injector_mc_if.slave  bus,
  input  logic                         cfg_use_cfg_latencies,
  input  logic [LAT_WIDTH-1:0]         cfg_latency_sram,
  input  logic [LAT_WIDTH-1:0]         cfg_latency_dram,
  input  logic [9:0]                   cfg_dram_hit_milli_pct,
  input  logic                         cfg_in_order,
  output logic [31:0]                  total_reqs,
  output logic [31:0]                  total_resp,
  output logic [31:0]                  dram_reqs,
  output logic [31:0]                  dram_hits,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  busy_cycles,
  output logic [$clog2(SLOTS):0]       max_occupancy,
  output logic                         busy
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int SEQ_W  = $clog2(SLOTS) + 1;
  localparam int OCC_W  = $clog2(SLOTS) + 1;
  localparam int SHIFT  = $clog2(DRAM_BYTES_PER_CYCLE);
  localparam int EXT_W  = LAT_WIDTH + SIZE_WIDTH + 1;

  logic [SLOTS-1:0]      slot_valid_q, slot_valid_d;
  logic [LAT_WIDTH-1:0]  slot_cnt_q  [SLOTS], slot_cnt_d  [SLOTS];
  logic [CH_W-1:0]       slot_ch_q   [SLOTS], slot_ch_d   [SLOTS];
  logic [ID_WIDTH-1:0]   slot_id_q   [SLOTS], slot_id_d   [SLOTS];
  logic [SIZE_WIDTH-1:0] slot_size_q [SLOTS], slot_size_d [SLOTS];
  logic [SEQ_W-1:0]      slot_seq_q  [SLOTS], slot_seq_d  [SLOTS];

  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SEQ_W-1:0]      issue_seq_q, issue_seq_d, retire_seq_q, retire_seq_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [CH_W-1:0]       resp_ch_q, resp_ch_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic [SIZE_WIDTH-1:0] resp_size_q, resp_size_d;
  logic [31:0]           total_reqs_q, total_reqs_d, total_resp_q, total_resp_d;
  logic [31:0]           dram_reqs_q, dram_reqs_d, dram_hits_q, dram_hits_d;
  logic [31:0]           stall_q, stall_d, busy_cyc_q, busy_cyc_d;
  logic [OCC_W-1:0]      max_occ_q, max_occ_d, occ_next;

  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       grant_ch, cand;
  logic                  grant_any, free_any, accept;
  logic [SLOT_W-1:0]     alloc_idx, ret_idx;
  logic                  alloc_found, ret_any, do_retire, handshake;
  logic                  req_dram, dram_hit;
  logic [SIZE_WIDTH-1:0] req_size;
  logic [ID_WIDTH-1:0]   req_id;
  logic [LAT_WIDTH-1:0]  lat_s, lat_d, miss_lat, new_lat;
  logic [9:0]            lfsr_mod;
  logic [EXT_W-1:0]      xfer, miss_sum;

  // Round-robin search starting at rr_ptr, wrapping over NUM_CH.
  always_comb begin
    grant     = '0;
    grant_ch  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_ch  = cand;
      end
    end
    if (grant_any) grant[grant_ch] = 1'b1;
  end

  // Free-slot status looks only at registered occupancy, so a slot retiring
  // this cycle cannot be reallocated until the next one.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!alloc_found && !slot_valid_q[s]) begin
        alloc_found = 1'b1;
        alloc_idx   = SLOT_W'(s);
      end
    end
  end

  assign free_any      = alloc_found;
  assign accept        = grant_any & free_any;
  assign bus.req_ready = grant & {NUM_CH{free_any}};

  assign req_dram = bus.req_is_dram[grant_ch];
  assign req_size = bus.req_size_bytes[int'(grant_ch)*SIZE_WIDTH +: SIZE_WIDTH];
  assign req_id   = bus.req_id[int'(grant_ch)*ID_WIDTH +: ID_WIDTH];

  // Latency is fixed at accept; the miss path adds ceil(size / bandwidth)
  // computed in a widened domain and then saturated to LAT_WIDTH.
  always_comb begin
    lat_s    = cfg_use_cfg_latencies ? cfg_latency_sram : LAT_WIDTH'(LATENCY_SRAM_CYCLES);
    lat_d    = cfg_use_cfg_latencies ? cfg_latency_dram : LAT_WIDTH'(LATENCY_DRAM_CYCLES);
    lfsr_mod = 10'(lfsr_q % 16'd1000);
    dram_hit = lfsr_mod < cfg_dram_hit_milli_pct;
    xfer     = (EXT_W'(req_size) + EXT_W'(DRAM_BYTES_PER_CYCLE - 1)) >> SHIFT;
    miss_sum = EXT_W'(lat_d) + xfer;
    miss_lat = (miss_sum > EXT_W'({LAT_WIDTH{1'b1}})) ? {LAT_WIDTH{1'b1}}
                                                      : miss_sum[LAT_WIDTH-1:0];
    new_lat  = (req_dram && !dram_hit) ? miss_lat : lat_s;
  end

  // In-order mode only lets the slot holding the next retire sequence go.
  always_comb begin
    ret_any = 1'b0;
    ret_idx = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!ret_any && slot_valid_q[s] && (slot_cnt_q[s] == '0) &&
          (!cfg_in_order || (slot_seq_q[s] == retire_seq_q))) begin
        ret_any = 1'b1;
        ret_idx = SLOT_W'(s);
      end
    end
  end

  assign handshake = resp_valid_q & bus.resp_ready;
  assign do_retire = ret_any & (!resp_valid_q | bus.resp_ready);

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_ch_d    = slot_ch_q;
    slot_id_d    = slot_id_q;
    slot_size_d  = slot_size_q;
    slot_seq_d   = slot_seq_q;
    for (int s = 0; s < SLOTS; s++) begin
      slot_cnt_d[s] = (slot_valid_q[s] && slot_cnt_q[s] != '0) ? slot_cnt_q[s] - 1'b1
                                                               : slot_cnt_q[s];
    end
    if (do_retire) slot_valid_d[ret_idx] = 1'b0;
    if (accept) begin
      slot_valid_d[alloc_idx] = 1'b1;
      slot_cnt_d[alloc_idx]   = new_lat;
      slot_ch_d[alloc_idx]    = grant_ch;
      slot_id_d[alloc_idx]    = req_id;
      slot_size_d[alloc_idx]  = req_size;
      slot_seq_d[alloc_idx]   = issue_seq_q;
    end

    occ_next = '0;
    for (int s = 0; s < SLOTS; s++) occ_next = occ_next + OCC_W'(slot_valid_d[s]);
    max_occ_d = (occ_next > max_occ_q) ? occ_next : max_occ_q;

    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
    issue_seq_d  = issue_seq_q + SEQ_W'(accept);
    retire_seq_d = retire_seq_q + SEQ_W'(do_retire);
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    resp_valid_d = resp_valid_q;
    resp_ch_d    = resp_ch_q;
    resp_id_d    = resp_id_q;
    resp_size_d  = resp_size_q;
    if (handshake) resp_valid_d = 1'b0;
    if (do_retire) begin
      resp_valid_d = 1'b1;
      resp_ch_d    = slot_ch_q[ret_idx];
      resp_id_d    = slot_id_q[ret_idx];
      resp_size_d  = slot_size_q[ret_idx];
    end

    total_reqs_d = total_reqs_q + 32'(accept);
    dram_reqs_d  = dram_reqs_q + 32'(accept & req_dram);
    dram_hits_d  = dram_hits_q + 32'(accept & req_dram & dram_hit);
    total_resp_d = total_resp_q + 32'(handshake);
    stall_d      = stall_q + 32'(resp_valid_q & !bus.resp_ready);
    busy_cyc_d   = busy_cyc_q + 32'(busy);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid_q <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_cnt_q[s]  <= '0;
        slot_ch_q[s]   <= '0;
        slot_id_q[s]   <= '0;
        slot_size_q[s] <= '0;
        slot_seq_q[s]  <= '0;
      end
      rr_ptr_q     <= '0;
      issue_seq_q  <= '0;
      retire_seq_q <= '0;
      lfsr_q       <= LFSR_SEED;
      resp_valid_q <= 1'b0;
      resp_ch_q    <= '0;
      resp_id_q    <= '0;
      resp_size_q  <= '0;
      total_reqs_q <= '0;
      total_resp_q <= '0;
      dram_reqs_q  <= '0;
      dram_hits_q  <= '0;
      stall_q      <= '0;
      busy_cyc_q   <= '0;
      max_occ_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_cnt_q   <= slot_cnt_d;
      slot_ch_q    <= slot_ch_d;
      slot_id_q    <= slot_id_d;
      slot_size_q  <= slot_size_d;
      slot_seq_q   <= slot_seq_d;
      rr_ptr_q     <= rr_ptr_d;
      issue_seq_q  <= issue_seq_d;
      retire_seq_q <= retire_seq_d;
      lfsr_q       <= lfsr_d;
      resp_valid_q <= resp_valid_d;
      resp_ch_q    <= resp_ch_d;
      resp_id_q    <= resp_id_d;
      resp_size_q  <= resp_size_d;
      total_reqs_q <= total_reqs_d;
      total_resp_q <= total_resp_d;
      dram_reqs_q  <= dram_reqs_d;
      dram_hits_q  <= dram_hits_d;
      stall_q      <= stall_d;
      busy_cyc_q   <= busy_cyc_d;
      max_occ_q    <= max_occ_d;
    end
  end

  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_ch         = resp_ch_q;
  assign bus.resp_id         = resp_id_q;
  assign bus.resp_size_bytes = resp_size_q;
  assign busy                = (|slot_valid_q) | resp_valid_q;
  assign total_reqs          = total_reqs_q;
  assign total_resp          = total_resp_q;
  assign dram_reqs           = dram_reqs_q;
  assign dram_hits           = dram_hits_q;
  assign stall_cycles        = stall_q;
  assign busy_cycles         = busy_cyc_q;
  assign max_occupancy       = max_occ_q;
endmodule

// File: tb/tb_memory_latency_injector_mc.sv
module tb_memory_latency_injector_mc;
  localparam int NUM_CH = 2, SIZE_WIDTH = 16, ID_WIDTH = 4, SLOTS = 8, LAT_WIDTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 cfg_use, cfg_in_order;
  logic [LAT_WIDTH-1:0] cfg_lat_s, cfg_lat_d;
  logic [9:0]           cfg_hit;
  logic [31:0]          total_reqs, total_resp, dram_reqs, dram_hits, stall_cycles, busy_cycles;
  logic [$clog2(SLOTS):0] max_occupancy;
  logic                 busy;

  memory_latency_injector_mc_if #(.NUM_CH(NUM_CH), .SIZE_WIDTH(SIZE_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

  memory_latency_injector_mc #(.NUM_CH(NUM_CH), .SIZE_WIDTH(SIZE_WIDTH), .ID_WIDTH(ID_WIDTH),
                               .SLOTS(SLOTS), .LAT_WIDTH(LAT_WIDTH)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cfg_use_cfg_latencies(cfg_use), .cfg_latency_sram(cfg_lat_s), .cfg_latency_dram(cfg_lat_d),
    .cfg_dram_hit_milli_pct(cfg_hit), .cfg_in_order(cfg_in_order),
    .total_reqs(total_reqs), .total_resp(total_resp), .dram_reqs(dram_reqs), .dram_hits(dram_hits),
    .stall_cycles(stall_cycles), .busy_cycles(busy_cycles), .max_occupancy(max_occupancy), .busy(busy)
  );

  typedef struct { int ch; int id; int size; } exp_t;
  typedef struct { int ch; int dram; int size; int id; int use_cfg; int lat_s; int lat_d; int hit; int exp_edges; } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int id, input int size);
    exp_t e;
    e.ch = ch; e.id = id; e.size = size;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every response handshake must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got id %0d expected no response", bus.resp_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_ch", bus.resp_ch, mon_e.ch);
        chk("sb_id", bus.resp_id, mon_e.id);
        chk("sb_size", bus.resp_size_bytes, mon_e.size);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_req();
    bus.req_valid = '0; bus.req_is_dram = '0; bus.req_size_bytes = '0; bus.req_id = '0;
  endtask

  // Tasks start and end one time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    clear_req();
    bus.resp_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_req(input int ch, input int dram, input int size, input int id);
    bus.req_valid = '0;
    bus.req_valid[ch] = 1'b1;
    bus.req_is_dram[ch] = (dram != 0);
    bus.req_size_bytes[ch*SIZE_WIDTH +: SIZE_WIDTH] = SIZE_WIDTH'(size);
    bus.req_id[ch*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'(id);
    #1 chk("req_ready", bus.req_ready[ch], 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic wait_resp(input int limit, output int n);
    n = 0;
    while (!bus.resp_valid && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (n >= limit) chk("resp_timeout", n, -1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (n >= limit) chk("idle_timeout", n, -1);
  endtask

  vec_t vecs[9];
  int n, e_reqs, e_dreqs, e_hits, e_resp, rv_seen;
  logic [31:0] cap;

  initial begin
    //           ch dram size id use lat_s lat_d hit  edges
    vecs[0] = '{0, 0,   4,  3, 0,  0,    0,    0,    3};
    vecs[1] = '{1, 1,   64, 5, 0,  0,    0,    0,    33};
    vecs[2] = '{1, 1,   64, 6, 0,  0,    0,    1000, 3};
    vecs[3] = '{0, 1,   65, 9, 0,  0,    0,    0,    34};
    vecs[4] = '{1, 0,   12, 1, 1,  0,    50,   0,    1};
    vecs[5] = '{0, 1,   1,  2, 1,  3,    5,    0,    7};
    vecs[6] = '{0, 1,   0,  4, 1,  3,    0,    0,    1};
    vecs[7] = '{1, 0,   8,  7, 1,  7,    0,    0,    8};
    vecs[8] = '{1, 1,   100,15,1,  4,    9,    1023, 5};

    cfg_use = 0; cfg_in_order = 0; cfg_lat_s = '0; cfg_lat_d = '0; cfg_hit = '0;
    do_reset();
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_total_reqs", total_reqs, 0);
    chk("rst_max_occ", max_occupancy, 0);

    e_reqs = 0; e_dreqs = 0; e_hits = 0; e_resp = 0;
    for (int i = 0; i < 9; i++) begin
      cfg_use   = vecs[i].use_cfg[0];
      cfg_lat_s = LAT_WIDTH'(vecs[i].lat_s);
      cfg_lat_d = LAT_WIDTH'(vecs[i].lat_d);
      cfg_hit   = 10'(vecs[i].hit);
      push_exp(vecs[i].ch, vecs[i].id, vecs[i].size);
      send_req(vecs[i].ch, vecs[i].dram, vecs[i].size, vecs[i].id);
      wait_resp(100, n);
      chk("lat_edges", n, vecs[i].exp_edges);
      @(posedge clk); #1;
      e_reqs++; e_resp++;
      if (vecs[i].dram != 0) e_dreqs++;
      if (vecs[i].dram != 0 && vecs[i].hit >= 1000) e_hits++;
      chk("total_reqs", total_reqs, e_reqs);
      chk("total_resp", total_resp, e_resp);
      chk("dram_reqs", dram_reqs, e_dreqs);
      chk("dram_hits", dram_hits, e_hits);
    end

    // Fill all slots from two always-valid channels.
    do_reset();
    cfg_use = 1; cfg_lat_s = 16'd100; bus.resp_ready = 1'b0;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      bus.req_id = {ID_WIDTH'(i), ID_WIDTH'(i)};
      bus.req_size_bytes = {SIZE_WIDTH'(8 + i), SIZE_WIDTH'(8 + i)};
      #1 chk("rr_grant", bus.req_ready, (i % 2 == 0) ? 1 : 2);
      push_exp(i % 2, i, 8 + i);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      #1 chk("full_ready", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    chk("full_max_occ", max_occupancy, 8);
    chk("full_total_reqs", total_reqs, 8);
    clear_req();
    bus.resp_ready = 1'b1;
    wait_idle(400);
    chk("full_total_resp", total_resp, 8);

    // Out-of-order: SRAM overtakes a DRAM miss.
    do_reset();
    cfg_use = 0; cfg_hit = 0; cfg_in_order = 0;
    push_exp(1, 2, 4); push_exp(0, 1, 64);
    send_req(0, 1, 64, 1);
    send_req(1, 0, 4, 2);
    wait_resp(100, n);
    chk("ooo_first_id", bus.resp_id, 2);
    wait_idle(200);

    // In-order: DRAM first, SRAM on the very next cycle.
    cfg_in_order = 1;
    push_exp(0, 1, 64); push_exp(1, 2, 4);
    send_req(0, 1, 64, 1);
    send_req(1, 0, 4, 2);
    wait_resp(100, n);
    chk("ino_first_id", bus.resp_id, 1);
    @(posedge clk); #1;
    chk("ino_next_valid", bus.resp_valid, 1);
    chk("ino_next_id", bus.resp_id, 2);
    wait_idle(200);
    cfg_in_order = 0;

    // Backpressure: five stalled cycles, then two back-to-back responses.
    do_reset();
    bus.resp_ready = 1'b0;
    push_exp(0, 7, 16); push_exp(1, 8, 32);
    send_req(0, 0, 16, 7);
    send_req(1, 0, 32, 8);
    wait_resp(100, n);
    chk("bp_first_id", bus.resp_id, 7);
    cap = {bus.resp_valid, 11'(bus.resp_ch), bus.resp_id, bus.resp_size_bytes};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", {bus.resp_valid, 11'(bus.resp_ch), bus.resp_id, bus.resp_size_bytes}, cap);
    end
    chk("bp_stall_cycles", stall_cycles, 5);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next_valid", bus.resp_valid, 1);
    chk("bp_next_id", bus.resp_id, 8);
    @(posedge clk); #1;
    chk("bp_total_resp", total_resp, 2);
    chk("bp_stall_after", stall_cycles, 5);
    wait_idle(50);

    // Asynchronous reset with four requests in flight.
    cfg_use = 1; cfg_lat_s = 16'd40;
    for (int i = 0; i < 4; i++) send_req(i % 2, 0, 4, i);
    #2 reset = 1'b1;
    #1;
    chk("arst_total_reqs", total_reqs, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    chk("arst_resp_valid", bus.resp_valid, 0);
    chk("arst_busy_cycles", busy_cycles, 0);
    chk("arst_max_occ", max_occupancy, 0);
    bus.req_valid[1] = 1'b1;
    #1 chk("arst_req_ready", bus.req_ready, 2);
    bus.req_valid = '0;
    rv_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) rv_seen++;
    end
    chk("arst_no_resp", rv_seen, 0);
    chk("arst_total_reqs_end", total_reqs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_latency_injector_mc.md
Name: memory_latency_injector_mc

Overview:
Multi-channel, multi-outstanding successor to the single-queue latency injector. NUM_CH request ports share a round-robin arbiter and a pool of SLOTS outstanding-request slots. Each slot counts down its own SRAM, DRAM or cache-hit latency, including a DRAM transfer-time term, and retires either out-of-order or in issue order. Responses carry channel and ID on a backpressured ready/valid channel. It sits between tile DMA engines and the performance model to drive stall counters.

Parameters:
NUM_CH, 2, number of request channels (1..8)
SIZE_WIDTH, 16, request size field width in bytes
ID_WIDTH, 4, per-request transaction ID width
SLOTS, 8, max outstanding requests (2..32)
LAT_WIDTH, 16, latency counter width
LATENCY_SRAM_CYCLES, 2, default SRAM/hit latency
LATENCY_DRAM_CYCLES, 30, default DRAM miss base latency
DRAM_BYTES_PER_CYCLE, 32, DRAM miss transfer bandwidth; power of two ≥1
LFSR_SEED, 16'h5A5A, hit-model LFSR reset value; must be non-zero

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_CH  per-channel request valid
req_is_dram  in  NUM_CH  1=DRAM, 0=SRAM
req_size_bytes  in  NUM_CH*SIZE_WIDTH  packed; channel c at [c*SIZE_WIDTH +: SIZE_WIDTH]
req_id  in  NUM_CH*ID_WIDTH  packed per-channel ID
req_ready  out  NUM_CH  per-channel accept
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_ch  out  clog2(NUM_CH) or 1  originating channel
resp_id  out  ID_WIDTH  echoed ID
resp_size_bytes  out  SIZE_WIDTH  echoed size
cfg_use_cfg_latencies  in  1  1=use the cfg_latency_* inputs
cfg_latency_sram  in  LAT_WIDTH  runtime SRAM latency
cfg_latency_dram  in  LAT_WIDTH  runtime DRAM latency
cfg_dram_hit_milli_pct  in  10  DRAM hit probability, 0..1000
cfg_in_order  in  1  1=retire strictly in acceptance order
total_reqs, total_resp, dram_reqs, dram_hits, stall_cycles, busy_cycles  out  32 each  telemetry
max_occupancy  out  clog2(SLOTS)+1  high-water mark of occupied slots
busy  out  1  any slot occupied or resp_valid high

Behaviour:
- Reset (asynchronous): all slots freed; in-flight requests discarded and never reported; resp_valid=0; resp_ch/id/size=0; all telemetry=0; round-robin pointer=0; sequence counters=0; LFSR=LFSR_SEED.
- Arbitration: at most one accept per cycle. Grant goes to the first channel with req_valid=1, searching from rr_ptr upward with wrap. req_ready[c] = grant[c] AND (free slot exists). Free-slot status uses registered state only, so a slot freed this cycle is reusable next cycle. On accept, rr_ptr ← granted channel + 1 (mod NUM_CH).
- Allocation: lowest-index free slot. The slot stores ch, id, size, issue seq (clog2(SLOTS)+1 bits, wraps) and latency L.
- Latency, computed once at accept; later cfg changes do not affect in-flight slots:
  - lat_s/lat_d = cfg values when cfg_use_cfg_latencies=1, else the parameters.
  - SRAM request: L = lat_s.
  - DRAM request: hit = (lfsr % 1000) < cfg_dram_hit_milli_pct, so any value ≥1000 always hits. Hit: L = lat_s. Miss: L = lat_d + ceil(size/DRAM_BYTES_PER_CYCLE).
  - L saturates at 2^LAT_WIDTH−1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
- Countdown: a slot loaded at edge t decrements on each following edge while non-zero. It becomes eligible to retire when its count is 0.
- Retire: one slot per cycle moves into the output register when the register is empty or is handshaking (resp_valid & resp_ready) that cycle. The slot is freed at that edge. With L=0 and no backpressure, resp_valid rises at edge t+L+1.
  - Out-of-order mode (cfg_in_order=0): the lowest-index eligible slot retires.
  - In-order mode (cfg_in_order=1): only the slot whose seq equals retire_seq may retire. retire_seq increments per retire.
- Output: resp_* held stable while resp_valid=1 and resp_ready=0.
- Telemetry:
  - total_reqs increments per accept.
  - dram_reqs increments per accepted DRAM request; dram_hits increments per hit.
  - total_resp increments per resp handshake.
  - stall_cycles increments per cycle with resp_valid & !resp_ready.
  - busy_cycles increments per cycle with busy=1.
  - All 32-bit counters wrap.
- Simultaneous accept and retire in one cycle: both occur, and occupancy is unchanged.
- All slots full: every req_ready=0; request inputs are ignored.

Test Plan:
- Reset, cfg_use=0, ch0 SRAM size 4 id 3 accepted at edge 0 -> resp_valid=1 after edge 3 with resp_ch=0, id=3, size=4; total_reqs=total_resp=1.
- cfg_hit=0, ch1 DRAM size 64 at edge 0 -> L=32, resp after edge 33; dram_reqs=1, dram_hits=0. Repeat with cfg_hit=1000 -> resp after edge 3, dram_hits=1.
- Both channels valid every cycle for 8 cycles, SLOTS=8 -> accepts alternate ch0,ch1,ch0,...; after 8 accepts req_ready=0 until a retire; max_occupancy=8.
- cfg_in_order=0: DRAM miss then SRAM -> SRAM responds first. Same sequence with cfg_in_order=1 -> DRAM responds first, SRAM immediately after.
- resp_ready held 0 for 5 cycles while a response is valid -> resp_* stable, stall_cycles=5, slots keep counting down, no loss.
- Assert reset while 4 requests are outstanding -> no resp_valid afterwards, all counters 0, req_ready=1 on the next cycle with a valid request present.
